// File: rtl/dmem_sram_responder.sv
// Behavioural data-side SRAM responder: one outstanding request, fixed latency,
// byte-lane writes into a word array, full-word reads.
module dmem_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_BUSY   = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [0:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [1:0]        r_a;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem [2**ADDR_W];

  logic       w_done;
  logic       w_err;
  logic [3:0] w_strb;

  // Address bits above the word index alias onto the same array.
  logic w_unused;
  assign w_unused = ^{addr[31:ADDR_W+2]};

  assign addr_ok = (r_state == S_IDLE) & req;
  assign w_done  = (r_state == S_BUSY) & (r_cnt == 4'd0);
  assign data_ok = w_done;
  assign err     = w_done & w_err;
  assign rdata   = w_done ? r_mem[r_idx] : 32'h0;

  always_comb begin
    w_strb = 4'b0000;
    w_err  = 1'b0;
    case (r_size)
      2'b00: w_strb = 4'b0001 << r_a;
      2'b01: begin
        if (r_a == 2'b00)      w_strb = 4'b0011;
        else if (r_a == 2'b10) w_strb = 4'b1100;
        else                   w_err  = 1'b1;
      end
      2'b10: begin
        if (r_a == 2'b00) w_strb = 4'b1111;
        else              w_err  = 1'b1;
      end
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_size  <= 2'b00;
      r_a     <= 2'b00;
      r_idx   <= '0;
      r_wdata <= 32'h0;
    end else if (r_state == S_IDLE) begin
      if (req) begin
        r_state <= S_BUSY;
        r_cnt   <= CNT_INIT;
        r_wr    <= wr;
        r_size  <= size;
        r_a     <= addr[1:0];
        r_idx   <= addr[ADDR_W+1:2];
        r_wdata <= wdata;
      end
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end else begin
      r_state <= S_IDLE;
    end
  end

  // Commit on the edge closing the data_ok cycle; a reset in that cycle drops it.
  always_ff @(posedge clk) begin
    if (w_done && r_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

endmodule
